// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a first-word-fall-through FIFO, LSB first, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_valid,
  output logic             fifo_rd_en,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      tx_count,
  output logic [2:0]       dbg_state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    baud_q, baud_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic [15:0]      count_q, count_d;
  logic             pop;
  logic             baud_last;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  assign baud_last   = (baud_q == BAUD_MAX);
  assign fifo_rd_en  = pop;
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE);
  assign tx_count    = count_q;
  assign dbg_state_o = state_q;

  // The bit counter also indexes stop bits, so a second stop bit needs no extra state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    count_d = count_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        pop    = fifo_valid;
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = par_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = shreg_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          if (bit_q == LAST_STOP) begin
            count_d = count_q + 1'b1;
            bit_d   = '0;
            state_d = S_IDLE;
            pop     = fifo_valid;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // A pop from either IDLE or the final stop cycle launches the next frame immediately.
    pop = pop & ~srst;
    if (pop) begin
      state_d = S_START;
      shreg_d = fifo_dout;
      tx_d    = 1'b0;
      baud_d  = '0;
      bit_d   = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^fifo_dout;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      count_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      count_q <= count_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds words, and a line model predicts tx, busy, rd_en and tx_count.
// Honours UART_TX_PARITY_EN in the line model.
module tb_fifo_uart_tx;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
  localparam int STOPS = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME = (1 + WIDTH + PBITS + STOPS) * CPB;

  logic             clk;
  logic             srst;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_valid;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic [15:0]      tx_count;
  logic [2:0]       dbg_state;

  fifo_uart_tx #(.WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .STOP_BITS(STOPS)) dut (
    .clk        (clk),
    .srst       (srst),
    .fifo_dout  (fifo_dout),
    .fifo_valid (fifo_valid),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .tx_count   (tx_count),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  bit mon_en = 1'b0;

  logic [WIDTH-1:0] fifo_q[$];
  logic             exp_q[$];
  logic [15:0]      exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line samples for one frame, one entry per clock cycle.
  function automatic void push_frame(input logic [WIDTH-1:0] w);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < WIDTH; i++) bits.push_back(w[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^w);
`endif
    for (int i = 0; i < STOPS; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
  endfunction

  // ---------------- FIFO model (first-word-fall-through) ----------------
  always @(posedge clk) begin
    logic p;
    p = (fifo_rd_en === 1'b1);
    #1;
    if (p && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_valid = (fifo_q.size() > 0);
    fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : WIDTH'($urandom);
  end

  // ---------------- line model / scoreboard ----------------
  always @(negedge clk) begin
    logic had, e_tx, e_rd;
    if (mon_en) begin
      had  = (exp_q.size() > 0);
      e_tx = had ? exp_q.pop_front() : 1'b1;
      e_rd = fifo_valid && !srst && (exp_q.size() == 0);
      chk("tx", 32'(tx), 32'(e_tx));
      chk("busy", 32'(busy), 32'(had));
      chk("rd_en", 32'(fifo_rd_en), 32'(e_rd));
      chk("tx_count", 32'(tx_count), 32'(exp_cnt));
      if (fifo_rd_en === 1'b1) rd_cnt++;
      if (srst) begin
        exp_q.delete();
        exp_cnt = '0;
      end else begin
        if (had && exp_q.size() == 0) exp_cnt = exp_cnt + 16'd1;
        if (e_rd) push_frame(fifo_dout);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0 || busy) && k < limit) begin
      cyc(1);
      k++;
    end
    chk("drain_in_time", 32'(k < limit), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rd0;
    int k;
    srst       = 1'b1;
    fifo_valid = 1'b0;
    fifo_dout  = '0;

    // reset and idle
    @(posedge clk);
    #3 mon_en = 1'b1;
    cyc(2);
    srst = 1'b0;
    cyc(50);
    chk("idle_count", 32'(tx_count), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pops", 32'(rd_cnt), 32'd0);

    // single frame
    rd0 = rd_cnt;
    push(8'hA5);
    wait_drain(200);
    chk("single_pops", 32'(rd_cnt - rd0), 32'd1);
    chk("single_count", 32'(tx_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);

    // back-to-back
    rd0 = rd_cnt;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    wait_drain(400);
    chk("b2b_pops", 32'(rd_cnt - rd0), 32'd3);
    chk("b2b_count", 32'(tx_count), 32'd4);

    // reset in the middle of DATA bit 3, with another word waiting
    rd0 = rd_cnt;
    push(8'h55);
    k = 0;
    while (rd_cnt == rd0 && k < 100) begin
      cyc(1);
      k++;
    end
    chk("mid_pop_seen", 32'(k < 100), 32'd1);
    cyc(17);
    srst = 1'b1;
    push(8'h96);
    cyc(2);
    srst = 1'b0;
    chk("mid_count_reset", 32'(tx_count), 32'd0);
    chk("mid_pops_during_reset", 32'(rd_cnt - rd0), 32'd1);
    wait_drain(200);
    chk("mid_pops_total", 32'(rd_cnt - rd0), 32'd2);
    chk("mid_count_after", 32'(tx_count), 32'd1);

    // parity-relevant words, then random traffic with random gaps
    push(8'h07);
    push(8'h03);
    for (int i = 0; i < 16; i++) begin
      push(WIDTH'($urandom));
      if ($urandom_range(0, 2) == 0) push(WIDTH'($urandom));
      cyc($urandom_range(0, 60));
    end
    wait_drain(3000);
    chk("random_busy", 32'(busy), 32'd0);

    // counter wrap
    force dut.count_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    cyc(1);
    release dut.count_q;
    cyc(2);
    push(8'hC3);
    wait_drain(200);
    chk("wrap_count", 32'(tx_count), 32'd0);

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
